nand_exerciser: RTL and testbench
=================================

Name: nand_exerciser

Overview:
- Self-checking stimulus driver for a 2-input NAND device under test.
- Drives the DUT inputs (a, b) through all four vectors for a fixed number of sweeps.
- Samples the DUT output z after a settle window and compares it against ~(a & b).
- Reports pass/fail, a mismatch count and the first failing vector. It sits on the board/bench side, opposite the gate.

Parameters:
- SETTLE_CYCLES, 2, cycles held in WAIT before sampling z (>=1); the DUT may have latency up to SETTLE_CYCLES+1 cycles.
- NUM_PASSES, 4, number of full 4-vector sweeps per run (>=1).
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; only accepted in IDLE.
- a_out  out  1  drive to DUT input a.
- b_out  out  1  drive to DUT input b.
- z_in  in  1  DUT output z.
- busy  out  1  high in DRIVE/WAIT/SAMPLE.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  1 = last run had zero mismatches; held until next accepted start.
- err_count  out  ERR_W  mismatch count of last/current run, saturating at 2^ERR_W-1.
- first_fail_vec  out  2  {a,b} of first mismatch in run.
- first_fail_valid  out  1  first_fail_vec is meaningful.

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0; state=IDLE, vec=0, pass_cnt=0, settle_cnt=0.
- rst asserted mid-run: every output and state takes its reset value at that edge; the run is abandoned with no done pulse.
- IDLE: on start=1, clear err_count, first_fail_*, pass; set vec=0, pass_cnt=0; a_out/b_out={vec}; go to DRIVE.
- DRIVE (1 cycle): a_out=vec[1], b_out=vec[0] are stable from entry; settle_cnt=0; go to WAIT.
- WAIT (SETTLE_CYCLES cycles): settle_cnt counts 0..SETTLE_CYCLES-1; at the last count go to SAMPLE.
- SAMPLE (1 cycle): on the exiting edge, compare z_in against ~(a_out & b_out).
  - On mismatch: err_count += 1, saturating at max.
  - If first_fail_valid=0, also capture first_fail_vec={a_out,b_out} and set first_fail_valid=1.
  - Next: if vec==3 and pass_cnt==NUM_PASSES-1, go to DONE. Else vec wraps 3->0 with pass_cnt+1 on wrap, load the new a_out/b_out, and go to DRIVE.
- DONE (1 cycle):
  - done=1, busy=0, a_out=b_out=0.
  - pass = (err_count==0). Saturation keeps err_count nonzero, so pass stays 0 on any failure.
  - Go to IDLE.
- Timing: per vector 2+SETTLE_CYCLES cycles; defaults give 16 vectors x 4 = 64 busy cycles, with done high in the 65th cycle after the start edge.
- start while busy or in DONE: ignored; the run is not extended or restarted.
- Results (pass, err_count, first_fail_*) hold in IDLE until the next accepted start.
- Simultaneous rst and start: rst wins.

Decomposition:
- nand_exerciser_pkg holds:
  - state encoding constants: IDLE, DRIVE, WAIT, SAMPLE, DONE (3 bits);
  - VEC_W=2;
  - the vector ordering 00,01,10,11.
- One sub-module, nand_exerciser_seq: the vec/pass_cnt sweep counter with wrap and last-vector flag.
- FSM, settle counter and checker stay in the top.

Test Plan:
1. Ideal combinational DUT, defaults, 1-cycle start -> busy for 64 cycles, done pulse once, pass=1, err_count=0, first_fail_valid=0.
2. z_in stuck at 1 -> fails only vector 11 each sweep: err_count=4, first_fail_vec=2'b11, first_fail_valid=1, pass=0.
3. z_in stuck at 0 -> fails 00,01,10 per sweep: err_count=12, first_fail_vec=2'b00, pass=0. Repeat with ERR_W=3 -> err_count saturates at 7, pass=0.
4. DUT with 3-cycle registered latency: SETTLE_CYCLES=2 -> pass=1, err_count=0; SETTLE_CYCLES=1 -> pass=0, err_count>0.
5. Second start pulse at cycle 10 of a run -> ignored; done still at cycle 65. Start asserted in the DONE cycle -> ignored; block returns to IDLE.
6. rst high at cycle 20 of a run -> next cycle all outputs at reset values, no done pulse; a fresh start then completes normally with pass=1.

Source files
------------

// File: rtl/nand_exerciser_pkg.sv
// Shared types and constants for the NAND gate exerciser: state encoding
// and the 2-bit {a,b} vector sweep order.
package nand_exerciser_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        WAIT   = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int VEC_W = 2;

    // Sweep order is 00,01,10,11; the last vector wraps back to the first.
    localparam logic [VEC_W-1:0] VEC_FIRST = 2'b00;
    localparam logic [VEC_W-1:0] VEC_LAST  = 2'b11;

    function automatic logic [VEC_W-1:0] vec_succ(input logic [VEC_W-1:0] v);
        return (v == VEC_LAST) ? VEC_FIRST : v + 1'b1;
    endfunction

endpackage

// File: rtl/nand_exerciser_seq.sv
// Sweep counter: walks {a,b} through the four vectors NUM_PASSES times and
// flags the final vector of the final sweep.
module nand_exerciser_seq
    import nand_exerciser_pkg::*;
#(
    parameter int NUM_PASSES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [VEC_W-1:0] vec_nxt_o,
    output logic             last_o
);

    localparam int PC_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    logic [VEC_W-1:0] vec_q, vec_d;
    logic [PC_W-1:0]  pass_cnt_q, pass_cnt_d;

    always_comb begin
        vec_d      = vec_q;
        pass_cnt_d = pass_cnt_q;
        if (clear_i) begin
            vec_d      = VEC_FIRST;
            pass_cnt_d = '0;
        end else if (advance_i) begin
            vec_d = vec_succ(vec_q);
            if (vec_q == VEC_LAST) begin
                pass_cnt_d = pass_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q      <= VEC_FIRST;
            pass_cnt_q <= '0;
        end else begin
            vec_q      <= vec_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

    assign vec_nxt_o = vec_succ(vec_q);
    assign last_o    = (vec_q == VEC_LAST) && (pass_cnt_q == PC_W'(NUM_PASSES - 1));

endmodule

// File: rtl/nand_exerciser.sv
// Board-side exerciser for a 2-input NAND: drives every {a,b} vector, waits
// a settle window, checks z against ~(a&b) and reports the run result.
module nand_exerciser
    import nand_exerciser_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic             z_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_fail_vec,
    output logic             first_fail_valid
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_e           state_q;
    logic [SC_W-1:0]  settle_q;
    logic             a_q, b_q, busy_q, done_q, pass_q, ffv_valid_q;
    logic [ERR_W-1:0] err_q;
    logic [1:0]       ffv_q;

    logic             mismatch;
    logic [ERR_W-1:0] err_d;
    logic             seq_clear, seq_adv, seq_last;
    logic [VEC_W-1:0] vec_nxt;

    always_comb begin
        mismatch = (z_in != ~(a_q & b_q));
        err_d    = err_q;
        if (mismatch && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + 1'b1;
        end
        seq_clear = (state_q == IDLE) && start;
        seq_adv   = (state_q == SAMPLE) && !seq_last;
    end

    nand_exerciser_seq #(
        .NUM_PASSES(NUM_PASSES)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (seq_clear),
        .advance_i(seq_adv),
        .vec_nxt_o(vec_nxt),
        .last_o   (seq_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            ffv_q       <= '0;
            ffv_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q       <= '0;
                        ffv_q       <= '0;
                        ffv_valid_q <= 1'b0;
                        pass_q      <= 1'b0;
                        a_q         <= VEC_FIRST[1];
                        b_q         <= VEC_FIRST[0];
                        busy_q      <= 1'b1;
                        state_q     <= DRIVE;
                    end
                end
                DRIVE: begin
                    settle_q <= '0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (settle_q == SC_W'(SETTLE_CYCLES - 1)) begin
                        state_q <= SAMPLE;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                SAMPLE: begin
                    err_q <= err_d;
                    if (mismatch && !ffv_valid_q) begin
                        ffv_q       <= {a_q, b_q};
                        ffv_valid_q <= 1'b1;
                    end
                    if (seq_last) begin
                        // Saturation never returns to zero, so any failure keeps pass low.
                        pass_q  <= (err_d == '0);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        a_q     <= vec_nxt[1];
                        b_q     <= vec_nxt[0];
                        state_q <= DRIVE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_out            = a_q;
    assign b_out            = b_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffv_valid_q;

endmodule

// File: tb/tb_nand_exerciser.sv
// Directed bench for nand_exerciser: ideal, stuck-at and latent NAND models,
// restart/DONE-start immunity, mid-run reset and counter saturation.
module tb_nand_exerciser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic aux_en = 1'b0;
    logic [1:0] mode = 2'd0;

    always #5 clk = ~clk;

    // main instance, default parameters
    logic       a, b, z, busy, done, pass, ffvalid;
    logic [7:0] err;
    logic [1:0] ffv;
    logic [2:0] pipe_main = 3'b111;

    // aux instances share a gated start
    logic       start_aux;
    logic       s_a, s_b, s_busy, s_done, s_pass, s_ffvalid;
    logic [2:0] s_err;
    logic [1:0] s_ffv;
    logic       zero_z;
    logic       l_a, l_b, l_z, l_busy, l_done, l_pass, l_ffvalid;
    logic [7:0] l_err;
    logic [1:0] l_ffv;
    logic [2:0] pipe_lat = 3'b111;

    assign start_aux = start & aux_en;
    assign zero_z    = 1'b0;
    assign l_z       = pipe_lat[2];

    always_comb begin
        case (mode)
            2'd0:    z = ~(a & b);
            2'd1:    z = 1'b1;
            2'd2:    z = 1'b0;
            default: z = pipe_main[2];
        endcase
    end

    always @(posedge clk) begin
        pipe_main <= {pipe_main[1:0], ~(a & b)};
        pipe_lat  <= {pipe_lat[1:0], ~(l_a & l_b)};
    end

    nand_exerciser u_dut (
        .clk(clk), .rst(rst), .start(start), .a_out(a), .b_out(b), .z_in(z),
        .busy(busy), .done(done), .pass(pass), .err_count(err),
        .first_fail_vec(ffv), .first_fail_valid(ffvalid)
    );

    nand_exerciser #(.ERR_W(3)) u_sat (
        .clk(clk), .rst(rst), .start(start_aux), .a_out(s_a), .b_out(s_b), .z_in(zero_z),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
        .first_fail_vec(s_ffv), .first_fail_valid(s_ffvalid)
    );

    nand_exerciser #(.SETTLE_CYCLES(1)) u_lat1 (
        .clk(clk), .rst(rst), .start(start_aux), .a_out(l_a), .b_out(l_b), .z_in(l_z),
        .busy(l_busy), .done(l_done), .pass(l_pass), .err_count(l_err),
        .first_fail_vec(l_ffv), .first_fail_valid(l_ffvalid)
    );

    int n_checks = 0;
    int n_fail = 0;
    int busy_cnt, busy_last, done_cnt, done_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, 32'({a, b, busy, done, pass, err, ffv, ffvalid}), 32'h0);
    endtask

    // Pulse start, then watch 70 cycles; cycle i is observed at the negedge
    // following the i-th rising edge after the start edge.
    task automatic run(input int restart_at, input int rst_at, input logic aux);
        busy_cnt  = 0;
        busy_last = 0;
        done_cnt  = 0;
        done_at   = 0;
        repeat (5) @(negedge clk);
        start  = 1'b1;
        aux_en = aux;
        @(negedge clk);
        start  = 1'b0;
        aux_en = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            if (i > 1) @(negedge clk);
            start = 1'b0;
            if (busy) begin
                busy_cnt++;
                busy_last = i;
            end
            if (done) begin
                done_cnt++;
                done_at = i;
            end
            if (i == restart_at) start = 1'b1;
            if (rst_at > 0 && i == rst_at) rst = 1'b1;
            if (rst_at > 0 && i == rst_at + 1) begin
                chk_reset("mid_run_rst_outputs");
                rst = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("reset_outputs");
        rst = 1'b0;

        // ideal gate; aux instances run alongside
        mode = 2'd0;
        run(0, 0, 1'b1);
        chk("ideal_busy_cnt", busy_cnt, 64);
        chk("ideal_busy_last", busy_last, 64);
        chk("ideal_done_cnt", done_cnt, 1);
        chk("ideal_done_at", done_at, 65);
        chk("ideal_pass", pass, 1);
        chk("ideal_err", err, 0);
        chk("ideal_ffvalid", ffvalid, 0);
        chk("sat_err", s_err, 7);
        chk("sat_pass", s_pass, 0);
        chk("sat_ffv", {s_ffvalid, s_ffv}, 3'b100);
        chk("lat1_err", l_err, 7);
        chk("lat1_ffv", {l_ffvalid, l_ffv}, 3'b111);
        chk("lat1_pass", l_pass, 0);

        mode = 2'd1;
        run(0, 0, 1'b0);
        chk("stuck1_err", err, 4);
        chk("stuck1_ffv", {ffvalid, ffv}, 3'b111);
        chk("stuck1_pass", pass, 0);
        chk("stuck1_done_at", done_at, 65);

        mode = 2'd2;
        run(0, 0, 1'b0);
        chk("stuck0_err", err, 12);
        chk("stuck0_ffv", {ffvalid, ffv}, 3'b100);
        chk("stuck0_pass", pass, 0);

        mode = 2'd3;
        run(0, 0, 1'b0);
        chk("lat3_pass", pass, 1);
        chk("lat3_err", err, 0);
        chk("lat3_ffv", {ffvalid, ffv}, 3'b000);

        mode = 2'd0;
        run(10, 0, 1'b0);
        chk("restart_busy_cnt", busy_cnt, 64);
        chk("restart_done_cnt", done_cnt, 1);
        chk("restart_done_at", done_at, 65);
        chk("restart_pass", pass, 1);

        run(65, 0, 1'b0);
        chk("done_start_busy_cnt", busy_cnt, 64);
        chk("done_start_busy_last", busy_last, 64);
        chk("done_start_done_cnt", done_cnt, 1);

        run(0, 20, 1'b0);
        chk("rst_busy_cnt", busy_cnt, 20);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_pass_held", pass, 0);

        run(0, 0, 1'b0);
        chk("fresh_done_at", done_at, 65);
        chk("fresh_pass", pass, 1);
        chk("fresh_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
